// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory access unit: RV32I load/store width codes,
// FSM state encoding and the request legality check.
package riscv_mem_pkg;

    localparam int ADDR_W_DEF = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_STB,
        S_MERGE,
        S_WR_ADDR,
        S_WR_STB,
        S_RESP
    } state_e;

    // Misaligned half/word, unused funct3 codes, and unsigned "stores" are all rejected.
    function automatic logic req_is_bad(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = we;
            F3_H:    bad = off[0];
            F3_HU:   bad = we | off[0];
            F3_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory word, and merges
// store bytes/halves into a previously read word.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [31:0] ins;

    always_comb begin
        case (off_i)
            2'd0:    byte_v = word_i[7:0];
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_o = {24'h0, byte_v};
            F3_H:    load_o = {{16{half_v[15]}}, half_v};
            F3_HU:   load_o = {16'h0, half_v};
            default: load_o = word_i;
        endcase
    end

    // Stores only reach the merge path as SB or SH; anything else passes the word through.
    always_comb begin
        shamt = {off_i, 3'b000};
        mask  = 32'h0;
        ins   = 32'h0;
        if (funct3_i == F3_B) begin
            mask = 32'h0000_00FF << shamt;
            ins  = (wdata_i & 32'h0000_00FF) << shamt;
        end else if (funct3_i == F3_H) begin
            shamt = {off_i[1], 4'b0000};
            mask  = 32'h0000_FFFF << shamt;
            ins   = (wdata_i & 32'h0000_FFFF) << shamt;
        end
        merged_o = (word_i & ~mask) | ins;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide strobe-driven data memory. Sub-word stores are done
// as read-modify-write; all outputs, including both strobes, come straight from flops.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_write,
    output logic              mem_writeBack,
    output logic [ADDR_W-1:0] d_addr,
    output logic [31:0]       dw_data,
    input  logic [31:0]       dr_data
);

    state_e              state_q, state_d;
    logic                req_ready_q, rsp_valid_q, rsp_err_q;
    logic                mem_write_q, mem_wb_q;
    logic [31:0]         rsp_rdata_q, dw_data_q, wdata_q;
    logic [ADDR_W-1:0]   d_addr_q;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [1:0]          off_q;
    logic                accept, bad;
    logic [31:0]         load_data, merged;
    logic                unused_addr_hi;

    // Upper address bits alias onto the same memory words.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign accept = req_valid && req_ready_q;
    assign bad    = req_is_bad(req_we, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .funct3_i (f3_q),
        .off_i    (off_q),
        .word_i   (dr_data),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .merged_o (merged)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bad)                    state_d = S_RESP;
                    else if (!req_we)           state_d = S_RD_ADDR;
                    else if (req_funct3 == F3_W) state_d = S_WR_ADDR;
                    else                        state_d = S_RD_ADDR;
                end
            end
            S_RD_ADDR: state_d = S_RD_STB;
            S_RD_STB:  state_d = we_q ? S_MERGE : S_RESP;
            S_MERGE:   state_d = S_WR_STB;
            S_WR_ADDR: state_d = S_WR_STB;
            S_WR_STB:  state_d = S_RESP;
            S_RESP:    if (rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_write_q <= 1'b0;
            mem_wb_q    <= 1'b0;
            d_addr_q    <= '0;
            dw_data_q   <= 32'h0;
            wdata_q     <= 32'h0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == S_IDLE);
            rsp_valid_q <= (state_d == S_RESP);
            mem_wb_q    <= (state_d == S_RD_STB);
            mem_write_q <= (state_d == S_WR_STB);
            if (accept) begin
                we_q        <= req_we;
                f3_q        <= req_funct3;
                off_q       <= req_addr[1:0];
                wdata_q     <= req_wdata;
                rsp_err_q   <= bad;
                rsp_rdata_q <= 32'h0;
                if (!bad) d_addr_q <= req_addr[ADDR_W+1:2];
                if (!bad && req_we) dw_data_q <= req_wdata;
            end
            // Memory latched dr_data on the strobe rise a full cycle ago; it is stable here.
            // The merged word is loaded as the read strobe falls, ahead of the write strobe.
            if (state_q == S_RD_STB) begin
                if (we_q) dw_data_q   <= merged;
                else      rsp_rdata_q <= load_data;
            end
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign mem_write     = mem_write_q;
    assign mem_writeBack = mem_wb_q;
    assign d_addr        = d_addr_q;
    assign dw_data       = dw_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: strobe-edge memory model, table of single transactions with a
// scoreboard queue, plus hand sequences for response back-pressure and reset mid-operation.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_write;
    logic        mem_writeBack;
    logic [7:0]  d_addr;
    logic [31:0] dw_data;
    logic [31:0] dr_data = 32'h0;

    mem_access_unit #(.ADDR_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_write     (mem_write),
        .mem_writeBack (mem_writeBack),
        .d_addr        (d_addr),
        .dw_data       (dw_data),
        .dr_data       (dr_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: writes and read-latches happen only on strobe rising edges.
    logic [31:0] mem [256];
    logic        pl_req = 1'b0;
    logic [7:0]  pl_addr = 8'h0;
    logic [31:0] pl_data = 32'h0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    always @(posedge mem_write or posedge pl_req) begin
        if (pl_req) mem[pl_addr] = pl_data;
        else begin
            mem[d_addr] = dw_data;
            wr_cnt++;
        end
    end

    always @(posedge mem_writeBack) begin
        dr_data = mem[d_addr];
        rd_cnt++;
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_req  = 1'b1;
        #1 pl_req = 1'b0;
    endtask

    // Protocol monitor: address/data settled before each strobe, strobes exclusive and 1 cycle.
    logic [7:0]  addr_prev;
    logic [31:0] data_prev;
    logic        wr_prev = 1'b0, wb_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_write && mem_writeBack) chk("strobes_exclusive", 32'd1, 32'd0);
        if (mem_write && wr_prev)       chk("mem_write_width", 32'd2, 32'd1);
        if (mem_writeBack && wb_prev)   chk("mem_writeBack_width", 32'd2, 32'd1);
        wr_prev   = mem_write;
        wb_prev   = mem_writeBack;
        addr_prev = d_addr;
        data_prev = dw_data;
    end

    always @(posedge mem_write) begin
        chk("wr_addr_setup", {24'h0, d_addr}, {24'h0, addr_prev});
        chk("wr_data_setup", dw_data, data_prev);
    end

    always @(posedge mem_writeBack) chk("rd_addr_setup", {24'h0, d_addr}, {24'h0, addr_prev});

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic [31:0] memw;
        int          wr;
        int          rd;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic [31:0] memw;
        int          wr;
        int          rd;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[15];

    // Drives one request, then waits (bounded) for the response and checks it against the queue.
    task automatic run_req(input vec_t v, input bit hold);
        exp_t e;
        int   lat, wr0, rd0;
        preload(8'h04, v.pre);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        chk("req_ready_idle", {31'h0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        sb.push_back('{v.rdata, v.err, v.lat, v.memw, v.wr, v.rd});
        n_vec++;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        e = sb.pop_front();
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", lat, e.lat);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        chk("mem_word", mem[4], e.memw);
        chk("write_pulses", wr_cnt - wr0, e.wr);
        chk("read_pulses", rd_cnt - rd0, e.rd);
        if (!e.err) chk("d_addr", {24'h0, d_addr}, 32'h4);
        if (hold) begin
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'd1);
                chk("hold_rsp_rdata", rsp_rdata, e.rdata);
                chk("hold_req_ready", {31'h0, req_ready}, 32'd0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("rsp_valid_drop", {31'h0, rsp_valid}, 32'd0);
        chk("req_ready_after", {31'h0, req_ready}, 32'd1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 3, 32'hDEADBEEF, 1, 0};
        tbl[1]  = '{1'b0, 3'b000, 32'h013, 32'h0,        32'h80FF7F01, 32'hFFFFFF80, 1'b0, 3, 32'h80FF7F01, 0, 1};
        tbl[2]  = '{1'b0, 3'b100, 32'h013, 32'h0,        32'h80FF7F01, 32'h00000080, 1'b0, 3, 32'h80FF7F01, 0, 1};
        tbl[3]  = '{1'b0, 3'b001, 32'h012, 32'h0,        32'h80FF7F01, 32'hFFFF80FF, 1'b0, 3, 32'h80FF7F01, 0, 1};
        tbl[4]  = '{1'b0, 3'b010, 32'h010, 32'h0,        32'h80FF7F01, 32'h80FF7F01, 1'b0, 3, 32'h80FF7F01, 0, 1};
        tbl[5]  = '{1'b0, 3'b101, 32'h012, 32'h0,        32'h80FF7F01, 32'h000080FF, 1'b0, 3, 32'h80FF7F01, 0, 1};
        tbl[6]  = '{1'b0, 3'b000, 32'h010, 32'h0,        32'h80FF7F01, 32'h00000001, 1'b0, 3, 32'h80FF7F01, 0, 1};
        tbl[7]  = '{1'b1, 3'b000, 32'h011, 32'h000000AA, 32'h11223344, 32'h0,        1'b0, 5, 32'h1122AA44, 1, 1};
        tbl[8]  = '{1'b1, 3'b001, 32'h012, 32'h0000BEEF, 32'h11223344, 32'h0,        1'b0, 5, 32'hBEEF3344, 1, 1};
        tbl[9]  = '{1'b1, 3'b000, 32'h013, 32'hFFFFFF55, 32'h11223344, 32'h0,        1'b0, 5, 32'h55223344, 1, 1};
        tbl[10] = '{1'b0, 3'b010, 32'h012, 32'h0,        32'h11223344, 32'h0,        1'b1, 1, 32'h11223344, 0, 0};
        tbl[11] = '{1'b1, 3'b001, 32'h011, 32'h0000BEEF, 32'h11223344, 32'h0,        1'b1, 1, 32'h11223344, 0, 0};
        tbl[12] = '{1'b0, 3'b011, 32'h010, 32'h0,        32'h11223344, 32'h0,        1'b1, 1, 32'h11223344, 0, 0};
        tbl[13] = '{1'b1, 3'b100, 32'h010, 32'h000000AA, 32'h11223344, 32'h0,        1'b1, 1, 32'h11223344, 0, 0};
        tbl[14] = '{1'b0, 3'b010, 32'h410, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3, 32'hCAFEF00D, 0, 1};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
        chk("rst_strobes", {30'h0, mem_write, mem_writeBack}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_d_addr", {24'h0, d_addr}, 32'h0);
        chk("rst_dw_data", dw_data, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) run_req(tbl[i], 1'b0);

        // Back-pressure on the response: outputs must hold until rsp_ready.
        run_req('{1'b0, 3'b010, 32'h010, 32'h0, 32'h80FF7F01, 32'h80FF7F01, 1'b0, 3, 32'h80FF7F01, 0, 1}, 1'b1);

        // Reset during the read strobe of an SB: strobes drop at once and no write ever happens.
        begin
            int wr0;
            preload(8'h04, 32'h11223344);
            wr0 = wr_cnt;
            n_vec++;
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'b000;
            req_addr   = 32'h011;
            req_wdata  = 32'h000000AA;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("midop_in_rd_stb", {31'h0, mem_writeBack}, 32'd1);
            rst_n = 1'b0;
            #1;
            chk("midop_strobes", {30'h0, mem_write, mem_writeBack}, 32'd0);
            chk("midop_req_ready", {31'h0, req_ready}, 32'd1);
            chk("midop_rsp_valid", {31'h0, rsp_valid}, 32'd0);
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("midop_no_write", wr_cnt - wr0, 32'd0);
            chk("midop_mem_kept", mem[4], 32'h11223344);
            chk("midop_req_ready_after", {31'h0, req_ready}, 32'd1);
        end

        run_req('{1'b0, 3'b010, 32'h010, 32'h0, 32'h11223344, 32'h11223344, 1'b0, 3, 32'h11223344, 0, 1}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
